// File: rtl/ad9361_rx_packer.sv
// AD9361 RX packer: formats both channels' IQ samples into {Q,I} words and interleaves them
// through a first-word-fall-through FIFO. Define AD9361_RX_PACKER_TLAST_EN to build m_last framing.
module ad9361_rx_packer #(
    parameter int DEPTH       = 16,
    parameter bit SIGN_EXTEND = 1'b1,
    parameter int FRAME_LEN   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                ch_en,
    input  logic                      valid_0,
    input  logic [11:0]               data_i0,
    input  logic [11:0]               data_q0,
    input  logic                      valid_1,
    input  logic [11:0]               data_i1,
    input  logic [11:0]               data_q1,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [31:0]               m_data,
    output logic                      m_chan,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    level,
    input  logic                      clr_ovf,
    output logic                      overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_bad_cfg
        $error("ad9361_rx_packer: DEPTH must be a power of 2 >= 4 and FRAME_LEN >= 1");
    end

    // Each entry is {chan, Q[15:0], I[15:0]}; pointers carry one extra wrap bit.
    logic [32:0]  mem [DEPTH];
    logic [AW:0]  wptr, rptr, wptr_1, req, free;
    logic [32:0]  word_0, word_1, head;
    logic         push_0, push_1, any_push, accept, drop, pop;

    function automatic logic [15:0] fmt(input logic [11:0] s);
        if (SIGN_EXTEND) return {{4{s[11]}}, s};
        else             return {s, 4'b0000};
    endfunction

    assign push_0   = valid_0 & ch_en[0];
    assign push_1   = valid_1 & ch_en[1];
    assign any_push = push_0 | push_1;
    assign req      = {{(AW-1){1'b0}}, push_0 & push_1, push_0 ^ push_1};

    // Space is judged before this cycle's pop, so a full FIFO drops even when popping.
    assign level    = wptr - rptr;
    assign free     = DEPTH_W - level;
    assign accept   = any_push && (req <= free);
    assign drop     = any_push && (req > free);

    assign word_0   = {1'b0, fmt(data_q0), fmt(data_i0)};
    assign word_1   = {1'b1, fmt(data_q1), fmt(data_i1)};
    assign wptr_1   = wptr + {{AW{1'b0}}, 1'b1};

    // Output stream: a word transfers on a cycle where m_valid and m_ready are both high;
    // m_data/m_chan hold steady while m_valid is high and m_ready is low.
    assign head     = mem[rptr[AW-1:0]];
    assign m_valid  = (level != '0);
    assign m_data   = m_valid ? head[31:0] : 32'h0;
    assign m_chan   = m_valid & head[32];
    assign pop      = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            if (push_0) mem[wptr[AW-1:0]] <= word_0;
            if (push_1) mem[push_0 ? wptr_1[AW-1:0] : wptr[AW-1:0]] <= word_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + req;
            if (pop)    rptr <= rptr + {{AW{1'b0}}, 1'b1};
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

`ifdef AD9361_RX_PACKER_TLAST_EN
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    logic [CW-1:0] pop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt <= '0;
        end else if (pop) begin
            pop_cnt <= (pop_cnt == LAST_CNT) ? '0 : pop_cnt + CW'(1);
        end
    end

    assign m_last = m_valid && (pop_cnt == LAST_CNT);
`else
    assign m_last = 1'b0;
`endif
endmodule

// File: tb/tb_ad9361_rx_packer.sv
// Directed bench for ad9361_rx_packer: vector table for formatting/interleave plus hand
// sequences for async reset, overflow/clear priority and frame marking under back-pressure.
module tb_ad9361_rx_packer;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 4;
`ifdef AD9361_RX_PACKER_TLAST_EN
    localparam bit TLAST = 1'b1;
`else
    localparam bit TLAST = 1'b0;
`endif
    localparam logic [31:0] A_SE = 32'h07FF_F800, B_SE = 32'hFFFF_0001;
    localparam logic [31:0] A_LJ = 32'h7FF0_8000, B_LJ = 32'hFFF0_0010;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  ch_en = 2'b11;
    logic        valid_0 = 1'b0, valid_1 = 1'b0, m_ready = 1'b0, clr_ovf = 1'b0;
    logic [11:0] data_i0 = '0, data_q0 = '0, data_i1 = '0, data_q1 = '0;
    logic        m_valid, m_chan, m_last, overflow;
    logic [31:0] m_data;
    logic [4:0]  level;
    logic        lj_valid, lj_chan, lj_last, lj_ovf;
    logic [31:0] lj_data;
    logic [4:0]  lj_level;

    int errors = 0, checks = 0;
    logic [32:0] exp_q[$];

    ad9361_rx_packer #(.DEPTH(DEPTH), .SIGN_EXTEND(1'b1), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
        .valid_0(valid_0), .data_i0(data_i0), .data_q0(data_q0),
        .valid_1(valid_1), .data_i1(data_i1), .data_q1(data_q1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
        .m_last(m_last), .level(level), .clr_ovf(clr_ovf), .overflow(overflow));

    ad9361_rx_packer #(.DEPTH(DEPTH), .SIGN_EXTEND(1'b0), .FRAME_LEN(FRAME_LEN)) dut_lj (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
        .valid_0(valid_0), .data_i0(data_i0), .data_q0(data_q0),
        .valid_1(valid_1), .data_i1(data_i1), .data_q1(data_q1),
        .m_valid(lj_valid), .m_ready(m_ready), .m_data(lj_data), .m_chan(lj_chan),
        .m_last(lj_last), .level(lj_level), .clr_ovf(clr_ovf), .overflow(lj_ovf));

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic        v0, v1, rdy, clr;
        logic        e_valid;
        logic [31:0] e_data, e_lj;
        logic        e_chan;
        logic [4:0]  e_level;
        logic        e_ovf, e_last;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [1:0] en, input logic v0, input logic v1,
                                input logic rdy, input logic clr, input logic e_valid,
                                input logic [31:0] e_data, input logic [31:0] e_lj,
                                input logic e_chan, input logic [4:0] e_level,
                                input logic e_ovf, input logic e_last);
        vec_t v;
        v.en = en; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.clr = clr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_lj = e_lj; v.e_chan = e_chan;
        v.e_level = e_level; v.e_ovf = e_ovf; v.e_last = e_last;
        return v;
    endfunction

    function automatic logic [15:0] se16(input logic [11:0] s);
        logic [15:0] r;
        r = {{4{s[11]}}, s};
        return r;
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs at the falling edge, observe 1 time unit later
    task automatic step(input logic [1:0] en, input logic v0, input logic [11:0] i0,
                        input logic [11:0] q0, input logic v1, input logic [11:0] i1,
                        input logic [11:0] q1, input logic rdy, input logic clr);
        @(negedge clk);
        ch_en = en; valid_0 = v0; data_i0 = i0; data_q0 = q0;
        valid_1 = v1; data_i1 = i1; data_q1 = q1; m_ready = rdy; clr_ovf = clr;
        #1;
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(2'b11, 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, rdy, clr);
    endtask

    task automatic push0(input logic [11:0] i, input logic [11:0] q, input logic rdy);
        step(2'b11, 1'b1, i, q, 1'b0, 12'h0, 12'h0, rdy, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", 33'(level), 33'd0);
        check("rst_valid", 33'(m_valid), 33'd0);
        check("rst_data", 33'(m_data), 33'd0);
        check("rst_ovf", 33'(overflow), 33'd0);
        check("rst_last", 33'(m_last), 33'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(2'b11, 0, 0, 1, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[1]  = mk(2'b11, 1, 0, 1, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[2]  = mk(2'b11, 0, 1, 1, 0,  1, A_SE,  A_LJ,  0, 5'd1, 0, 0);
        vecs[3]  = mk(2'b11, 0, 0, 1, 0,  1, B_SE,  B_LJ,  1, 5'd1, 0, 0);
        vecs[4]  = mk(2'b11, 0, 0, 1, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[5]  = mk(2'b11, 1, 1, 0, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[6]  = mk(2'b11, 0, 0, 0, 0,  1, A_SE,  A_LJ,  0, 5'd2, 0, 0);
        vecs[7]  = mk(2'b11, 0, 0, 1, 0,  1, A_SE,  A_LJ,  0, 5'd2, 0, 0);
        vecs[8]  = mk(2'b11, 0, 0, 1, 0,  1, B_SE,  B_LJ,  1, 5'd1, 0, 1);
        vecs[9]  = mk(2'b11, 0, 0, 0, 1,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[10] = mk(2'b01, 1, 1, 0, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
        vecs[11] = mk(2'b10, 1, 1, 0, 0,  1, A_SE,  A_LJ,  0, 5'd1, 0, 0);
        vecs[12] = mk(2'b00, 1, 1, 0, 0,  1, A_SE,  A_LJ,  0, 5'd2, 0, 0);
        vecs[13] = mk(2'b11, 0, 0, 1, 0,  1, A_SE,  A_LJ,  0, 5'd2, 0, 0);
        vecs[14] = mk(2'b11, 0, 0, 1, 0,  1, B_SE,  B_LJ,  1, 5'd1, 0, 0);
        vecs[15] = mk(2'b11, 0, 0, 0, 0,  0, 32'h0, 32'h0, 0, 5'd0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", 33'(m_valid), 33'd0);
        check("reset_level", 33'(level), 33'd0);
        check("reset_ovf", 33'(overflow), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table: ch0 sample A (i=800,q=7FF), ch1 sample B (i=001,q=FFF)
        for (int n = 0; n < 16; n++) begin
            step(vecs[n].en, vecs[n].v0, 12'h800, 12'h7FF, vecs[n].v1, 12'h001, 12'hFFF,
                 vecs[n].rdy, vecs[n].clr);
            check($sformatf("v%0d_valid", n), 33'(m_valid), 33'(vecs[n].e_valid));
            check($sformatf("v%0d_data", n), 33'(m_data), 33'(vecs[n].e_data));
            check($sformatf("v%0d_lj", n), 33'(lj_data), 33'(vecs[n].e_lj));
            check($sformatf("v%0d_chan", n), 33'(m_chan), 33'(vecs[n].e_chan));
            check($sformatf("v%0d_level", n), 33'(level), 33'(vecs[n].e_level));
            check($sformatf("v%0d_ovf", n), 33'(overflow), 33'(vecs[n].e_ovf));
            check($sformatf("v%0d_last", n), 33'(m_last), 33'(TLAST & vecs[n].e_last));
        end

        // async reset mid-stream with 5 words queued
        for (int k = 0; k < 5; k++) push0(12'(k), 12'(k), 1'b0);
        idle(1'b0, 1'b0);
        check("pre_rst_level", 33'(level), 33'd5);
        async_reset();

        // fill to 15, then overflow behaviour and clear priority
        for (int k = 0; k < 7; k++) begin
            logic [11:0] ia, qa, ib, qb;
            ia = 12'(k * 291 + 7); qa = 12'hF00 ^ 12'(k);
            ib = 12'h800 | 12'(k); qb = 12'(k * 5);
            step(2'b11, 1'b1, ia, qa, 1'b1, ib, qb, 1'b0, 1'b0);
            exp_q.push_back({1'b0, se16(qa), se16(ia)});
            exp_q.push_back({1'b1, se16(qb), se16(ib)});
        end
        push0(12'hABC, 12'h123, 1'b0);
        exp_q.push_back({1'b0, 16'hFABC, 16'h0123 << 16 >> 16} | 33'h0);
        exp_q[14] = {1'b0, 16'h0123, 16'hFABC};
        step(2'b11, 1'b1, 12'h111, 12'h222, 1'b1, 12'h333, 12'h444, 1'b0, 1'b0);
        check("fill_level", 33'(level), 33'd15);
        check("fill_ovf", 33'(overflow), 33'd0);
        push0(12'h7FE, 12'h801, 1'b0);
        exp_q.push_back({1'b0, 16'hF801, 16'h07FE});
        check("drop_level", 33'(level), 33'd15);
        check("drop_ovf", 33'(overflow), 33'd1);
        step(2'b11, 1'b1, 12'h555, 12'h666, 1'b1, 12'h777, 12'h888, 1'b0, 1'b1);
        check("single_level", 33'(level), 33'd16);
        idle(1'b0, 1'b1);
        check("set_wins_ovf", 33'(overflow), 33'd1);
        check("full_level", 33'(level), 33'd16);
        push0(12'h999, 12'h999, 1'b1);
        check("clr_ovf", 33'(overflow), 33'd0);
        idle(1'b0, 1'b0);
        check("full_pop_level", 33'(level), 33'd15);
        check("full_pop_ovf", 33'(overflow), 33'd1);
        void'(exp_q.pop_front());
        for (int k = 0; k < 15; k++) begin
            logic [32:0] e;
            idle(1'b1, 1'b1);
            e = exp_q.pop_front();
            check($sformatf("drain%0d_valid", k), 33'(m_valid), 33'd1);
            check($sformatf("drain%0d_word", k), {m_chan, m_data}, e);
        end
        idle(1'b0, 1'b0);
        check("drained_level", 33'(level), 33'd0);
        check("drained_ovf", 33'(overflow), 33'd0);

        // frame marking with m_ready toggling 1,0 across 10 queued words
        async_reset();
        for (int k = 0; k < 10; k++) begin
            push0(12'(k + 16), 12'(k + 32), 1'b0);
            exp_q.push_back({1'b0, se16(12'(k + 32)), se16(12'(k + 16))});
        end
        begin
            int popped;
            popped = 0;
            for (int c = 0; c < 22; c++) begin
                logic rdy, ev;
                rdy = (c % 2 == 0);
                ev = (popped < 10);
                idle(rdy, 1'b0);
                check($sformatf("tl%0d_valid", c), 33'(m_valid), 33'(ev));
                check($sformatf("tl%0d_last", c), 33'(m_last),
                      33'(TLAST && ev && (popped % FRAME_LEN == FRAME_LEN - 1)));
                if (rdy && ev) begin
                    check($sformatf("tl%0d_word", c), {m_chan, m_data}, exp_q.pop_front());
                    popped++;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ad9361_rx_packer.md
Name: ad9361_rx_packer

Overview:
Downstream stage of the AD9361 CMOS RX handler. Consumes its two per-channel IQ sample streams (valid_0/data_i0/data_q0, valid_1/data_i1/data_q1) in the same clock domain and formats each sample into a 32-bit {Q,I} word. Interleaves channel 0 and channel 1 words into one FIFO and presents them on a valid/ready stream toward DMA or the baseband core. Reports overflow and FIFO level.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of 2, at least 4.
SIGN_EXTEND, 1, 1: each 12-bit sample sign-extended to 16 bits; 0: left-justified (sample in bits [15:4], bits [3:0] zero).
FRAME_LEN, 256, words per frame for m_last (used only with the optional feature); at least 1.

Ports:
clk  in  1  core clock, the same clock that drives the RX handler's sample registers.
rst_n  in  1  asynchronous active-low reset.
ch_en  in  2  per-channel enable; bit k gates channel k.
valid_0  in  1  channel 0 sample strobe.
data_i0  in  12  channel 0 I sample.
data_q0  in  12  channel 0 Q sample.
valid_1  in  1  channel 1 sample strobe.
data_i1  in  12  channel 1 I sample.
data_q1  in  12  channel 1 Q sample.
m_valid  out  1  output word available.
m_ready  in  1  consumer accepts the word.
m_data  out  32  {Q[15:0], I[15:0]}.
m_chan  out  1  channel index of m_data.
m_last  out  1  frame boundary (optional feature).
level  out  log2(DEPTH)+1  FIFO occupancy.
clr_ovf  in  1  single-cycle clear for overflow.
overflow  out  1  sticky drop flag.

Behaviour:
- Reset (rst_n low, asynchronous): write and read pointers 0; m_valid 0, m_data 0, m_chan 0, m_last 0, level 0, overflow 0. Memory contents are not reset.
- Channel k contributes a word in a cycle when valid_k and ch_en[k] are both high. 0, 1 or 2 words are requested per cycle.
- Each word is stored with its channel bit (33-bit entry).
- Two words in the same cycle: the ch0 word is written at wptr and the ch1 word at wptr+1; wptr advances by 2 (modulo 2*DEPTH, extra wrap bit).
- Free space is DEPTH - level, evaluated before this cycle's pop.
  - If free space is less than the words requested, all words of that cycle are dropped (no partial write).
  - On a drop, overflow is set.
- overflow clears when clr_ovf=1. If set and clear coincide in the same cycle, set wins.
- Output is first-word-fall-through: m_valid = (level != 0); m_data and m_chan come from mem[rptr].
- A pop occurs when m_valid and m_ready are both high; rptr advances by 1.
- m_data and m_chan are held stable while m_valid=1 and m_ready=0.
- Latency: a word accepted at edge N is visible on m_valid after edge N (0-cycle fall-through once in memory). This is one cycle after the sample strobe is sampled.
- Same-cycle push and pop: level_next = level + pushes - pop. With level=DEPTH, a pop does not free space for a same-cycle push; that push is dropped.
- Empty FIFO with a same-cycle push: no pop is possible that cycle (m_valid was 0).
- ch_en changes take effect in the same cycle; words already queued are unaffected.
- Sign extension: I[15:0] = {4{i[11]}, i}.
- Left-justified mode: I[15:0] = {i, 4'b0}. Q is formatted the same way.

Optional Feature:
Macro AD9361_RX_PACKER_TLAST_EN.
- Defined: a pop counter from 0 to FRAME_LEN-1 counts accepted words. m_last=1 while m_valid and the counter equals FRAME_LEN-1. The counter wraps to 0 on that pop and resets to 0 on rst_n.
- Not defined: m_last is tied 0 and no counter logic is built.

Test Plan:
- Reset then idle → m_valid=0, level=0, overflow=0. Assert rst_n low mid-stream with level=5 → level=0 and m_valid=0 immediately, without waiting for a clock edge.
- ch_en=2'b11; alternate valid_0 (i=0x800, q=0x7FF) and valid_1 (i=0x001, q=0xFFF); m_ready=1; SIGN_EXTEND=1 → words 0x07FFF800 chan0 and 0xFFFF0001 chan1, in order, 1 cycle after each strobe.
- Same sample values with SIGN_EXTEND=0 → 0x7FF08000 and 0xFFF00010.
- valid_0 and valid_1 in the same cycle, m_ready=0 → level goes 0→2; first pop gives m_chan=0, second gives m_chan=1.
- m_ready=0, DEPTH=16; fill to level=15, then a dual-channel cycle → both words dropped, level stays 15, overflow=1.
  - Next cycle, one ch0 word → written, level=16.
  - clr_ovf and a new drop in the same cycle → overflow stays 1.
- TLAST_EN, FRAME_LEN=4: stream 10 words with m_ready toggling 1,0 → m_last high on the 4th and 8th accepted words only; held high while m_ready=0 stalls the word.
